uart_rx: RTL

// - 8N1 UART receiver, counterpart of the UART_TX transmitter. Same link, same clocking.
// - Deserialises rxIN into bytes and presents each one on a valid/ack handshake.
// - Sits between the board RX pin and the co-processor command decoder.

---
 rtl/uart_rx.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver, companion of the UART_TX transmitter.
//
// Deserialises the asynchronous rxIN line into bytes and hands each byte to
// the command decoder on a valid/ack handshake.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> frame is start + 8 data + even parity + stop; parity
//                mismatches are flagged on rxParityErrOUT with the byte.
//   undefined -> plain 8N1, rxParityErrOUT tied to 0.
//
// Ports:
//   clockIN        in   system clock, all logic on posedge
//   nTxResetIN     in   asynchronous active-low reset
//   rxIN           in   serial line, idle high, asynchronous to clockIN
//   rxDataOUT      out  received byte (LSB first on the line)
//   rxValidOUT     out  rxDataOUT holds an unconsumed byte
//   rxAckIN        in   consumer takes the byte (only honoured while valid)
//   rxBusyOUT      out  a frame is in progress
//   rxFrameErrOUT  out  one-cycle pulse when the stop bit is sampled low
//   rxOverrunOUT   out  sticky: unacked byte was overwritten; cleared by ack
//   rxParityErrOUT out  parity error for the current byte
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clockIN,
    input  logic       nTxResetIN,
    input  logic       rxIN,
    output logic [7:0] rxDataOUT,
    output logic       rxValidOUT,
    input  logic       rxAckIN,
    output logic       rxBusyOUT,
    output logic       rxFrameErrOUT,
    output logic       rxOverrunOUT,
    output logic       rxParityErrOUT
);

    localparam int BIT_CYCLES  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = $clog2(BIT_CYCLES);

    localparam logic [CW-1:0] BIT_RELOAD  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta;
    logic          rx_sync;
    logic [1:0]    primed;
    logic          seen_high;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] counter;
    logic [CW-1:0] counter_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          tick;
    logic          deliver;
    logic          frame_err;

`ifdef UART_RX_PARITY_EN
    logic          parity_bad;
    logic          parity_bad_next;
`endif

    // Two-flop synchroniser. Both stages reset high so reset looks like an
    // idle line rather than a start bit.
    always_ff @(posedge clockIN or negedge nTxResetIN) begin
        if (!nTxResetIN) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rxIN;
            rx_sync <= rx_meta;
        end
    end

    // The synchroniser outputs are only genuine line samples two cycles after
    // reset. seen_high arms start detection only once a real high level has
    // been observed, so a line held low through reset never starts a frame
    // and every start needs a fresh 1->0 edge.
    always_ff @(posedge clockIN or negedge nTxResetIN) begin
        if (!nTxResetIN) begin
            primed    <= 2'b00;
            seen_high <= 1'b0;
        end else begin
            primed    <= {primed[0], 1'b1};
            seen_high <= seen_high | (primed[1] & rx_sync);
        end
    end

    // State register.
    always_ff @(posedge clockIN or negedge nTxResetIN) begin
        if (!nTxResetIN) begin
            state   <= S_IDLE;
            counter <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clockIN or negedge nTxResetIN) begin
        if (!nTxResetIN) begin
            parity_bad <= 1'b0;
        end else begin
            parity_bad <= parity_bad_next;
        end
    end
`endif

    assign tick = (counter == '0);

    // Next-state logic. Every sample is taken when the down-counter reaches
    // zero; the START reload is half a bit so later samples land mid-bit.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        deliver      = 1'b0;
        frame_err    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad;
`endif
        case (state)
            S_IDLE: begin
                if (seen_high && !rx_sync) begin
                    counter_next = HALF_RELOAD;
                    state_next   = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_sync) begin
                        state_next = S_IDLE;
                    end else begin
                        counter_next = BIT_RELOAD;
                        bit_idx_next = 3'd0;
                        state_next   = S_DATA;
                    end
                end else begin
                    counter_next = counter - CW'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_next[bit_idx] = rx_sync;
                    counter_next        = BIT_RELOAD;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    counter_next = counter - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    // Even parity: data bits plus parity bit XOR to zero.
                    parity_bad_next = rx_sync ^ (^shift);
                    counter_next    = BIT_RELOAD;
                    state_next      = S_STOP;
                end else begin
                    counter_next = counter - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    // Returning to IDLE mid stop bit leaves half a bit of
                    // margin to catch an immediately following start edge.
                    if (rx_sync) begin
                        deliver    = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    counter_next = counter - CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_sync) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output holding register. A delivery always wins over an ack in the same
    // cycle (the new byte stays valid); overrun is raised only when an unacked
    // byte is overwritten.
    always_ff @(posedge clockIN or negedge nTxResetIN) begin
        if (!nTxResetIN) begin
            rxDataOUT     <= '0;
            rxValidOUT    <= 1'b0;
            rxOverrunOUT  <= 1'b0;
            rxFrameErrOUT <= 1'b0;
        end else begin
            rxFrameErrOUT <= frame_err;
            if (deliver) begin
                rxDataOUT    <= shift;
                rxValidOUT   <= 1'b1;
                rxOverrunOUT <= rxValidOUT & ~rxAckIN;
            end else if (rxAckIN && rxValidOUT) begin
                rxValidOUT   <= 1'b0;
                rxOverrunOUT <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clockIN or negedge nTxResetIN) begin
        if (!nTxResetIN) begin
            rxParityErrOUT <= 1'b0;
        end else if (deliver) begin
            rxParityErrOUT <= parity_bad;
        end else if (rxAckIN && rxValidOUT) begin
            rxParityErrOUT <= 1'b0;
        end
    end
`else
    assign rxParityErrOUT = 1'b0;
`endif

    assign rxBusyOUT = (state != S_IDLE);

endmodule
